// File: rtl/fsm_pkg.sv
`default_nettype none
// ============================================================================
// fsm_pkg : shared state, opcode, nsel and vsel encodings for the RISC control
// Revision : 1.0
// ============================================================================
package fsm_pkg;

    localparam logic [2:0] ST_WAIT   = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_WIMM   = 3'd2;
    localparam logic [2:0] ST_GETA   = 3'd3;
    localparam logic [2:0] ST_GETB   = 3'd4;
    localparam logic [2:0] ST_EXEC   = 3'd5;
    localparam logic [2:0] ST_CMP    = 3'd6;
    localparam logic [2:0] ST_WREG   = 3'd7;

    typedef enum logic [2:0] {
        S_WAIT   = ST_WAIT,
        S_DECODE = ST_DECODE,
        S_WIMM   = ST_WIMM,
        S_GETA   = ST_GETA,
        S_GETB   = ST_GETB,
        S_EXEC   = ST_EXEC,
        S_CMP    = ST_CMP,
        S_WREG   = ST_WREG
    } state_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE  = 3'b000;
    localparam logic [2:0] NSEL_RN    = 3'b001;
    localparam logic [2:0] NSEL_RD    = 3'b010;
    localparam logic [2:0] NSEL_RM    = 3'b100;

    localparam logic [3:0] VSEL_MDATA = 4'b1000;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_C     = 4'b0001;

    // Single-operand ops pass B straight through the ALU with A forced to zero.
    function automatic logic zero_a_op(input logic [2:0] opc, input logic [1:0] sub);
        return ((opc == OPC_MOV) && (sub == OP_MOV_REG)) ||
               ((opc == OPC_ALU) && (sub == OP_MVN));
    endfunction

    function automatic logic vsel_legal(input logic [3:0] v);
        return (v == VSEL_MDATA) || (v == VSEL_IMM8) ||
               (v == VSEL_PC)    || (v == VSEL_C);
    endfunction

endpackage : fsm_pkg
`default_nettype wire

// File: rtl/fsm_ctrl.sv
`default_nettype none
// ============================================================================
// fsm_ctrl : multi-cycle Moore control FSM sequencing the RISC datapath
// Revision : 1.0
// ============================================================================
module fsm_ctrl
    import fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [3:0] vsel,
    output logic       write
);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] sub_q, sub_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_WAIT;
            op_q    <= 3'b000;
            sub_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sub_q   <= sub_d;
        end
    end

    // Instruction is captured once so the decoder may move on mid-instruction.
    always_comb begin
        op_d  = op_q;
        sub_d = sub_q;
        if ((state_q == S_WAIT) && s) begin
            op_d  = opcode;
            sub_d = op;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_WAIT: begin
                if (s) state_d = S_DECODE;
            end
            S_DECODE: begin
                if ((op_q == OPC_MOV) && (sub_q == OP_MOV_IMM))
                    state_d = S_WIMM;
                else if ((op_q == OPC_MOV) && (sub_q == OP_MOV_REG))
                    state_d = S_GETB;
                else if ((op_q == OPC_ALU) && (sub_q == OP_MVN))
                    state_d = S_GETB;
                else if ((op_q == OPC_ALU) &&
                         ((sub_q == OP_ADD) || (sub_q == OP_CMP) || (sub_q == OP_AND)))
                    state_d = S_GETA;
                else
                    state_d = S_WAIT;
            end
            S_WIMM:  state_d = S_WAIT;
            S_GETA:  state_d = S_GETB;
            S_GETB: begin
                if ((op_q == OPC_ALU) && (sub_q == OP_CMP))
                    state_d = S_CMP;
                else
                    state_d = S_EXEC;
            end
            S_EXEC:  state_d = S_WREG;
            S_CMP:   state_d = S_WAIT;
            S_WREG:  state_d = S_WAIT;
            default: state_d = S_WAIT;
        endcase
    end

    always_comb begin
        w     = 1'b0;
        nsel  = NSEL_NONE;
        loada = 1'b0;
        loadb = 1'b0;
        loadc = 1'b0;
        loads = 1'b0;
        asel  = 1'b0;
        bsel  = 1'b0;
        vsel  = VSEL_C;
        write = 1'b0;
        case (state_q)
            S_WAIT: w = 1'b1;
            S_WIMM: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM8;
                write = 1'b1;
            end
            S_GETA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            S_GETB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            S_EXEC: begin
                asel  = zero_a_op(op_q, sub_q);
                loadc = 1'b1;
            end
            S_CMP:  loads = 1'b1;
            S_WREG: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule : fsm_ctrl
`default_nettype wire

// File: tb/tb_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fsm_ctrl : randomized self-checking bench against a per-cycle output schedule
// Revision : 1.0
// ============================================================================
module tb_fsm_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic       w, loada, loadb, loadc, loads, asel, bsel, write;
    logic [2:0] nsel;
    logic [3:0] vsel;

    fsm_ctrl u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .s       (s),
        .opcode  (opcode),
        .op      (op),
        .w       (w),
        .nsel    (nsel),
        .loada   (loada),
        .loadb   (loadb),
        .loadc   (loadc),
        .loads   (loads),
        .asel    (asel),
        .bsel    (bsel),
        .vsel    (vsel),
        .write   (write)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write}
    logic [14:0] obs;
    assign obs = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write};

    function automatic logic [14:0] pk(input logic ww, input logic [2:0] ns, input logic [3:0] ld,
                                       input logic as, input logic bs, input logic [3:0] vs,
                                       input logic wr);
        return {ww, ns, ld, as, bs, vs, wr};
    endfunction

    localparam logic [14:0] IDLE  = {1'b1, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0};
    localparam logic [14:0] BUSY  = {1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0};

    logic [14:0] exp_q[$];

    // Expected output per cycle after the s-sampling edge, ending with the idle cycle.
    task automatic build(input logic [2:0] oc, input logic [1:0] o);
        logic mov_imm, mov_reg, mvn, alu2, cmp;
        mov_imm = (oc == 3'b110) && (o == 2'b10);
        mov_reg = (oc == 3'b110) && (o == 2'b00);
        mvn     = (oc == 3'b101) && (o == 2'b11);
        alu2    = (oc == 3'b101) && (o != 2'b11);
        cmp     = (oc == 3'b101) && (o == 2'b01);
        exp_q.delete();
        exp_q.push_back(BUSY);
        if (mov_imm) begin
            exp_q.push_back(pk(1'b0, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1));
        end else if (mov_reg || mvn) begin
            exp_q.push_back(pk(1'b0, 3'b100, 4'b0100, 1'b0, 1'b0, 4'b0001, 1'b0));
            exp_q.push_back(pk(1'b0, 3'b000, 4'b0010, 1'b1, 1'b0, 4'b0001, 1'b0));
            exp_q.push_back(pk(1'b0, 3'b010, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1));
        end else if (alu2) begin
            exp_q.push_back(pk(1'b0, 3'b001, 4'b1000, 1'b0, 1'b0, 4'b0001, 1'b0));
            exp_q.push_back(pk(1'b0, 3'b100, 4'b0100, 1'b0, 1'b0, 4'b0001, 1'b0));
            if (cmp) begin
                exp_q.push_back(pk(1'b0, 3'b000, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b0));
            end else begin
                exp_q.push_back(pk(1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 4'b0001, 1'b0));
                exp_q.push_back(pk(1'b0, 3'b010, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1));
            end
        end
        exp_q.push_back(IDLE);
    endtask

    function automatic int latency(input logic [2:0] oc, input logic [1:0] o);
        if (oc == 3'b110 && o == 2'b10) return 3;
        if (oc == 3'b110 && o == 2'b00) return 5;
        if (oc == 3'b101 && o == 2'b11) return 5;
        if (oc == 3'b101 && o == 2'b01) return 5;
        if (oc == 3'b101)               return 6;
        return 2;
    endfunction

    task automatic check_invariants();
        check_eq("inv_loads", 32'($countones({loada, loadb, loadc, loads}) <= 1), 32'd1);
        check_eq("inv_nsel",  32'($countones(nsel) <= 1), 32'd1);
    endtask

    // Called at a sample point with the DUT idle; returns idle at a sample point.
    task automatic run_instr(input logic [2:0] oc, input logic [1:0] o);
        int got_lat;
        s = 1'b1; opcode = oc; op = o;
        build(oc, o);
        @(posedge clk); #1;
        s = 1'b0;
        opcode = 3'($urandom); op = 2'($urandom);
        got_lat = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                opcode = 3'($urandom); op = 2'($urandom);
            end
            check_eq($sformatf("cyc%0d_op%0h_%0h", k + 1, oc, o), 32'(obs), 32'(exp_q[k]));
            check_invariants();
            if (w && got_lat == 0) got_lat = k + 1;
        end
        check_eq($sformatf("latency_op%0h_%0h", oc, o), 32'(got_lat), 32'(latency(oc, o)));
    endtask

    logic [2:0] legal_opc [6] = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101};
    logic [1:0] legal_sub [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};

    initial begin
        reset_n = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00;
        #1;
        check_eq("reset_async", 32'(obs), 32'(IDLE));
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_eq("reset_idle", 32'(obs), 32'(IDLE));

        // Idle with s low must hold regardless of decoder inputs.
        for (int i = 0; i < 3; i++) begin
            opcode = 3'($urandom); op = 2'($urandom);
            @(posedge clk); #1;
            check_eq("idle_hold", 32'(obs), 32'(IDLE));
        end

        // Directed: each legal op, then an illegal one.
        for (int i = 0; i < 6; i++) run_instr(legal_opc[i], legal_sub[i]);
        run_instr(3'b111, 2'($urandom));

        // Reset in the middle of an ADD, while loadb is asserted.
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        @(posedge clk); #1 s = 1'b0; opcode = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("add_getb_loadb", 32'(loadb), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("reset_mid_add", 32'(obs), 32'(IDLE));
        @(posedge clk); #1;
        check_eq("reset_held", 32'(obs), 32'(IDLE));
        reset_n = 1'b1;
        run_instr(3'b110, 2'b10);

        // Illegal with s held high re-enters decode straight from the idle cycle.
        s = 1'b1; opcode = 3'b111; op = 2'($urandom);
        @(posedge clk); #1;
        check_eq("illegal_decode", 32'(obs), 32'(BUSY));
        opcode = 3'b110; op = 2'b10;
        @(posedge clk); #1;
        check_eq("illegal_back_idle", 32'(obs), 32'(IDLE));
        @(posedge clk); #1;
        check_eq("sheld_redecode", 32'(obs), 32'(BUSY));
        s = 1'b0; opcode = 3'b000;
        @(posedge clk); #1;
        check_eq("sheld_wimm", 32'(obs), 32'(pk(1'b0, 3'b001, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b1)));
        @(posedge clk); #1;
        check_eq("sheld_done", 32'(obs), 32'(IDLE));

        // Randomized mix, biased towards legal instructions.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_instr(3'($urandom), 2'($urandom));
            end else begin
                int j;
                j = $urandom_range(0, 5);
                run_instr(legal_opc[j], legal_sub[j]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fsm_ctrl
`default_nettype wire

// File: doc/fsm_ctrl.md
Name: fsm_ctrl

Overview:
- Multi-cycle control FSM for the simple RISC datapath.
- Consumes opcode/op from the instruction decoder and sequences register-file reads and writes, A/B/C/status loads and the datapath mux selects.
- Drives nsel back to the decoder, which maps it to readnum/writenum.
- Executes one instruction per start pulse and signals idle via w.

Parameters:
- None. All encodings are fixed in fsm_pkg.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- s  in  1  start; sampled only in S_WAIT
- opcode  in  3  instruction class from decoder (IR[15:13])
- op  in  2  sub-op from decoder (IR[12:11])
- w  out  1  1 = idle in S_WAIT, ready for s
- nsel  out  3  one-hot register select: 001 Rn, 010 Rd, 100 Rm, 000 none
- loada  out  1  load A register
- loadb  out  1  load B register
- loadc  out  1  load C register
- loads  out  1  load status flags
- asel  out  1  1 = ALU A input forced to 0
- bsel  out  1  1 = ALU B input is sximm5
- vsel  out  4  one-hot writeback select: 1000 mdata, 0100 sximm8, 0010 PC, 0001 C
- write  out  1  register-file write enable

Behaviour:
- Reset and clock:
  - One clock domain (clk). Reset is asynchronous and active-low (reset_n).
  - reset_n=0 forces state S_WAIT immediately, including mid-instruction. No partial write survives.
  - Reset output values: w=1, nsel=000, loada=loadb=loadc=loads=0, asel=bsel=0, vsel=0001, write=0.
- Outputs and default values:
  - Moore outputs, decoded purely from the state register. No input-to-output combinational path.
  - Defaults in every state unless listed below: nsel=000, all loads 0, asel=0, bsel=0, vsel=0001, write=0, w=0.
- Instruction latching:
  - In S_WAIT with s=1, opcode and op are registered into op_q and sub_q.
  - All later transitions use op_q and sub_q, so decoder inputs may change mid-instruction.
  - s while busy is ignored. s held high re-triggers on the next S_WAIT cycle.
- States and transitions:
  - S_WAIT: w=1. If s=1 go to S_DECODE, else stay.
  - S_DECODE, by op_q/sub_q:
    - 110/10 (MOV imm) -> S_WIMM
    - 110/00 (MOV reg) -> S_GETB
    - 101/11 (MVN) -> S_GETB
    - 101/00, 101/01, 101/10 -> S_GETA
    - anything else (illegal) -> S_WAIT, with no load or write asserted
  - S_WIMM: nsel=001, vsel=0100, write=1 -> S_WAIT
  - S_GETA: nsel=001, loada=1 -> S_GETB
  - S_GETB: nsel=100, loadb=1. Go to S_CMP if 101/01, else S_EXEC.
  - S_EXEC: asel=1 for MOV reg or MVN, else 0. bsel=0, loadc=1 -> S_WREG
  - S_CMP: asel=0, bsel=0, loads=1 -> S_WAIT (no writeback)
  - S_WREG: nsel=010, vsel=0001, write=1 -> S_WAIT
- Latency (cycles from the s-sampling edge until w=1 again):
  - MOV imm: 3
  - MOV reg: 5
  - MVN: 5
  - CMP: 5
  - ADD/AND: 6
- Invariants:
  - write=1 only in S_WIMM and S_WREG.
  - At most one of loada/loadb/loadc/loads is high in any cycle.
  - nsel is always one-hot or zero.

Decomposition:
- fsm_pkg holds:
  - state_t enum (S_WAIT, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_CMP, S_WREG)
  - opcode constants OPC_MOV=110, OPC_ALU=101
  - op constants for MOV_IMM, MOV_REG, ADD, CMP, AND, MVN
  - NSEL_RN/RD/RM/NONE
  - VSEL_MDATA/IMM8/PC/C
- The decoder shares the same NSEL constants from fsm_pkg.
- No sub-module. The next-state logic, output decode and op latch live in one file.

Test Plan:
- Reset mid-ADD (in S_GETB): drop reset_n -> same cycle w=1, loadb=0. After release, s=1 with MOV imm completes normally with write pulse in cycle 2.
- MOV imm (s=1, 110/10): cycle 2 shows nsel=001, vsel=0100, write=1 for exactly one cycle. w=1 at cycle 3.
- ADD (101/00), with opcode changed to 000 after s:
  - loada at cycle 2 (nsel=001), loadb at cycle 3 (nsel=100), loadc at cycle 4 (asel=0), write at cycle 5 (nsel=010, vsel=0001).
  - Changed inputs are ignored.
- CMP (101/01): loads=1 at cycle 4, write never asserted, w=1 at cycle 5.
- MVN (101/11) and MOV reg (110/00): no loada; loadb at cycle 2; loadc with asel=1 at cycle 3; write at cycle 4.
- Illegal opcode 111 with s=1: back to S_WAIT at cycle 2. No load/write pulses. s held high restarts S_DECODE immediately.
